pixel_stream_arb: RTL and testbench

PIXEL_STREAM_ARB -- requirements
Module: pixel_stream_arb

---
 rtl/pixel_stream_arb_if.sv | 42 ++++
 rtl/pixel_stream_arb.sv | 146 ++++++++++++++
 tb/tb_pixel_stream_arb.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_arb_if.sv
// pixel_stream_arb_if -- handshake bundle between the draw-engine sources,
// the pixel stream arbiter and the downstream pixel sink.
//
// Signals:
//   in_data   [NCH*DATA_W]  channel i word at [i*DATA_W +: DATA_W]
//   in_valid  [NCH]         per-channel word valid
//   in_last   [NCH]         per-channel packet end
//   in_ready  [NCH]         per-channel word accepted (arbiter driven)
//   out_data  [DATA_W]      held forwarded word
//   out_valid               out_data holds a word not yet taken
//   out_last                packet end flag of the held word
//   out_ch    [SEL_W]       source channel of the held word
//   out_ready               downstream takes the held word
//
// Modports:
//   master  sources + sink side (testbench / surrounding logic)
//   slave   arbiter side
interface pixel_stream_arb_if #(
  parameter int DATA_W = 16,
  parameter int NCH    = 8,
  parameter int SEL_W  = 4
);
  logic [NCH*DATA_W-1:0] in_data;
  logic [NCH-1:0]        in_valid;
  logic [NCH-1:0]        in_last;
  logic [NCH-1:0]        in_ready;
  logic [DATA_W-1:0]     out_data;
  logic                  out_valid;
  logic                  out_last;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_ch
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_ch
  );
endinterface

// File: rtl/pixel_stream_arb.sv
// pixel_stream_arb -- packet-aware arbiter that merges NCH draw-engine pixel
// streams into one registered output stream. A channel, once granted, keeps
// the grant until its last beat has been accepted, so packets never interleave.
//
// Ports:
//   CLK      rising-edge clock
//   RST      synchronous active-high reset
//   MODE     0 = fixed select by SEL, 1 = round-robin over valid channels
//   SEL      channel index for fixed mode; all-ones means idle
//   sel_err  one-cycle flag: SEL out of range while idle in fixed mode
//   bus      pixel_stream_arb_if.slave handshake bundle
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no packet open; grant chosen combinationally from MODE/SEL/valids
// LOCKED | packet open on lock_ch; grant held until its last beat is accepted
module pixel_stream_arb #(
  parameter int                 DATA_W        = 16,
  parameter int                 NCH           = 8,
  parameter int                 SEL_W         = 4,
  parameter logic [DATA_W-1:0]  DEFAULT_COLOR = 16'hF000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MODE,
  input  logic [SEL_W-1:0]  SEL,
  output logic              sel_err,
  pixel_stream_arb_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [SEL_W-1:0] SEL_IDLE = '1;

  state_t            state;
  logic [SEL_W-1:0]  lock_ch;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  rr_next;
  logic [SEL_W-1:0]  gnt_ch;
  logic              gnt_vld;
  logic [DATA_W-1:0] gnt_word;
  logic              gnt_word_valid;
  logic              gnt_word_last;
  logic              load_ok;
  logic              accept;
  logic              sel_bad;
  logic              rr_found;
  int                rr_idx;
  int                nxt;

  // The output register can take a new word if empty or being drained now.
  assign load_ok = !bus.out_valid || bus.out_ready;

  // Grant selection. Channel indices are matched with loops rather than
  // direct indexing so SEL_W-wide indices never address past NCH.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_ch   = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    if (state == LOCKED) begin
      gnt_vld = 1'b1;
      gnt_ch  = lock_ch;
    end else if (!MODE) begin
      for (int i = 0; i < NCH; i++) begin
        if (int'(SEL) == i && bus.in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_ch  = SEL;
        end
      end
    end else begin
      // Search from rr_ptr upward, wrapping at NCH; first valid channel wins.
      for (int k = 0; k < NCH; k++) begin
        rr_idx = int'(rr_ptr) + k;
        if (rr_idx >= NCH) rr_idx = rr_idx - NCH;
        for (int i = 0; i < NCH; i++) begin
          if (!rr_found && i == rr_idx && bus.in_valid[i]) begin
            rr_found = 1'b1;
            gnt_vld  = 1'b1;
            gnt_ch   = SEL_W'(i);
          end
        end
      end
    end
  end

  // Granted channel's word and the per-channel ready vector.
  always_comb begin
    gnt_word       = '0;
    gnt_word_valid = 1'b0;
    gnt_word_last  = 1'b0;
    bus.in_ready   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_vld && int'(gnt_ch) == i) begin
        gnt_word       = bus.in_data[i*DATA_W +: DATA_W];
        gnt_word_valid = bus.in_valid[i];
        gnt_word_last  = bus.in_last[i];
        bus.in_ready[i] = load_ok && !RST;
      end
    end
  end

  assign accept = gnt_vld && gnt_word_valid && load_ok && !RST;

  always_comb begin
    nxt = int'(gnt_ch) + 1;
    if (nxt >= NCH) nxt = 0;
    rr_next = SEL_W'(nxt);
  end

  // Only meaningful while idle in fixed mode; all-ones is the legal idle code.
  assign sel_bad = (state == IDLE) && !MODE && (int'(SEL) >= NCH) && (SEL != SEL_IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      lock_ch       <= '0;
      rr_ptr        <= '0;
      sel_err       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= DEFAULT_COLOR;
      bus.out_ch    <= '1;
    end else begin
      sel_err <= sel_bad;
      if (accept) begin
        // A load also covers a simultaneous downstream take: the new word
        // simply replaces the one leaving, keeping one word per cycle.
        bus.out_data  <= gnt_word;
        bus.out_last  <= gnt_word_last;
        bus.out_ch    <= gnt_ch;
        bus.out_valid <= 1'b1;
        if (gnt_word_last) begin
          state  <= IDLE;
          rr_ptr <= rr_next;
        end else begin
          state   <= LOCKED;
          lock_ch <= gnt_ch;
        end
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_arb.sv
// tb_pixel_stream_arb -- self-checking bench for pixel_stream_arb: directed
// scenarios with constant expectations plus a randomized run checked against
// a packet-ownership reference model.
module tb_pixel_stream_arb;
  localparam int DATA_W = 16;
  localparam int NCH    = 8;
  localparam int SEL_W  = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             MODE;
  logic [SEL_W-1:0] SEL;
  logic             sel_err;

  int n_tests = 0;
  int n_fail  = 0;

  pixel_stream_arb_if #(.DATA_W(DATA_W), .NCH(NCH), .SEL_W(SEL_W)) bus ();

  pixel_stream_arb #(
    .DATA_W(DATA_W), .NCH(NCH), .SEL_W(SEL_W), .DEFAULT_COLOR(16'hF000)
  ) dut (
    .CLK(CLK), .RST(RST), .MODE(MODE), .SEL(SEL), .sel_err(sel_err), .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_in();
    bus.in_data  = '0;
    bus.in_valid = '0;
    bus.in_last  = '0;
  endtask

  task automatic drive(input int ch, input logic [DATA_W-1:0] d, input logic last);
    bus.in_data[ch*DATA_W +: DATA_W] = d;
    bus.in_valid[ch] = 1'b1;
    bus.in_last[ch]  = last;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_in();
    MODE = 1'b0;
    SEL = 4'hF;
    bus.out_ready = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    MODE = 1'b0;
    SEL = 4'd0;
    bus.out_ready = 1'b1;
    clear_in();
    drive(0, 16'h1234, 1'b1);
    @(negedge CLK);
    n_tests++;
    if (bus.in_ready !== 8'h00) begin n_fail++; $display("FAIL reset_in_ready got=%h exp=%h", bus.in_ready, 8'h00); end
    tick();
    clear_in();
    RST = 1'b0;
    n_tests++;
    if ({bus.out_valid, bus.out_last, bus.out_ch, bus.out_data} !== {1'b0, 1'b0, 4'hF, 16'hF000}) begin
      n_fail++; $display("FAIL reset_out got=%h exp=%h", {bus.out_valid, bus.out_last, bus.out_ch, bus.out_data}, {1'b0, 1'b0, 4'hF, 16'hF000}); end
    n_tests++;
    if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err got=%b exp=0", sel_err); end
  endtask

  task automatic test_fixed_packet();
    logic [DATA_W-1:0] beats [3] = '{16'hA001, 16'hA002, 16'hA003};
    do_reset();
    SEL = 4'd2;
    for (int b = 0; b < 3; b++) begin
      drive(2, beats[b], b == 2);
      @(negedge CLK);
      n_tests++;
      if (bus.in_ready !== 8'b0000_0100) begin n_fail++; $display("FAIL fixed_ready beat%0d got=%h exp=%h", b, bus.in_ready, 8'b0000_0100); end
      tick();
      n_tests++;
      if ({bus.out_valid, bus.out_last, bus.out_ch, bus.out_data} !== {1'b1, b == 2, 4'd2, beats[b]}) begin
        n_fail++; $display("FAIL fixed_out beat%0d got=%h exp=%h", b, {bus.out_valid, bus.out_last, bus.out_ch, bus.out_data}, {1'b1, b == 2, 4'd2, beats[b]}); end
    end
    clear_in();
    SEL = 4'd3;
    drive(3, 16'hB00B, 1'b1);
    @(negedge CLK);
    n_tests++;
    if (bus.in_ready !== 8'b0000_1000) begin n_fail++; $display("FAIL fixed_idle_after_last got=%h exp=%h", bus.in_ready, 8'b0000_1000); end
    tick();
    clear_in();
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fixed_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_lock_switch();
    do_reset();
    SEL = 4'd1;
    drive(1, 16'hB001, 1'b0);
    drive(3, 16'hC001, 1'b1);
    @(negedge CLK);
    n_tests++;
    if (bus.in_ready !== 8'b0000_0010) begin n_fail++; $display("FAIL lock_first got=%h exp=%h", bus.in_ready, 8'b0000_0010); end
    tick();
    SEL = 4'd3;
    drive(1, 16'hB002, 1'b0);
    @(negedge CLK);
    n_tests++;
    if (bus.in_ready !== 8'b0000_0010) begin n_fail++; $display("FAIL lock_hold got=%h exp=%h", bus.in_ready, 8'b0000_0010); end
    tick();
    bus.in_valid[1] = 1'b0;
    @(negedge CLK);
    n_tests++;
    if (bus.in_ready !== 8'b0000_0010) begin n_fail++; $display("FAIL lock_stall got=%h exp=%h", bus.in_ready, 8'b0000_0010); end
    tick();
    drive(1, 16'hB003, 1'b1);
    @(negedge CLK);
    n_tests++;
    if (bus.in_ready !== 8'b0000_0010) begin n_fail++; $display("FAIL lock_last got=%h exp=%h", bus.in_ready, 8'b0000_0010); end
    tick();
    n_tests++;
    if ({bus.out_last, bus.out_ch, bus.out_data} !== {1'b1, 4'd1, 16'hB003}) begin
      n_fail++; $display("FAIL lock_last_out got=%h exp=%h", {bus.out_last, bus.out_ch, bus.out_data}, {1'b1, 4'd1, 16'hB003}); end
    bus.in_valid[1] = 1'b0;
    @(negedge CLK);
    n_tests++;
    if (bus.in_ready !== 8'b0000_1000) begin n_fail++; $display("FAIL lock_switch_ch3 got=%h exp=%h", bus.in_ready, 8'b0000_1000); end
    tick();
    n_tests++;
    if ({bus.out_ch, bus.out_data} !== {4'd3, 16'hC001}) begin
      n_fail++; $display("FAIL lock_switch_out got=%h exp=%h", {bus.out_ch, bus.out_data}, {4'd3, 16'hC001}); end
    clear_in();
  endtask

  task automatic test_rr_order();
    int order [4] = '{0, 3, 5, 0};
    do_reset();
    MODE = 1'b1;
    drive(0, 16'h0D00, 1'b1);
    drive(3, 16'h0D03, 1'b1);
    drive(5, 16'h0D05, 1'b1);
    for (int n = 0; n < 4; n++) begin
      logic [NCH-1:0] exp_rdy;
      exp_rdy = '0;
      exp_rdy[order[n]] = 1'b1;
      @(negedge CLK);
      n_tests++;
      if (bus.in_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready step%0d got=%h exp=%h", n, bus.in_ready, exp_rdy); end
      tick();
      n_tests++;
      if (bus.out_ch !== 4'(order[n])) begin n_fail++; $display("FAIL rr_out_ch step%0d got=%0d exp=%0d", n, bus.out_ch, order[n]); end
    end
    clear_in();
  endtask

  task automatic test_backpressure();
    do_reset();
    SEL = 4'd4;
    bus.out_ready = 1'b0;
    drive(4, 16'hD001, 1'b1);
    @(negedge CLK);
    n_tests++;
    if (bus.in_ready !== 8'b0001_0000) begin n_fail++; $display("FAIL bp_first got=%h exp=%h", bus.in_ready, 8'b0001_0000); end
    tick();
    drive(4, 16'hD002, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      n_tests++;
      if (bus.in_ready !== 8'h00) begin n_fail++; $display("FAIL bp_stall_ready cyc%0d got=%h exp=%h", c, bus.in_ready, 8'h00); end
      tick();
      n_tests++;
      if ({bus.out_valid, bus.out_data} !== {1'b1, 16'hD001}) begin
        n_fail++; $display("FAIL bp_hold cyc%0d got=%h exp=%h", c, {bus.out_valid, bus.out_data}, {1'b1, 16'hD001}); end
    end
    bus.out_ready = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (bus.in_ready !== 8'b0001_0000) begin n_fail++; $display("FAIL bp_release got=%h exp=%h", bus.in_ready, 8'b0001_0000); end
    tick();
    n_tests++;
    if ({bus.out_valid, bus.out_data} !== {1'b1, 16'hD002}) begin
      n_fail++; $display("FAIL bp_next got=%h exp=%h", {bus.out_valid, bus.out_data}, {1'b1, 16'hD002}); end
    clear_in();
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_sel_err();
    do_reset();
    SEL = 4'd9;
    bus.in_valid = '1;
    @(negedge CLK);
    n_tests++;
    if (bus.in_ready !== 8'h00) begin n_fail++; $display("FAIL selerr_ready got=%h exp=%h", bus.in_ready, 8'h00); end
    tick();
    n_tests++;
    if ({sel_err, bus.out_valid, bus.out_data} !== {1'b1, 1'b0, 16'hF000}) begin
      n_fail++; $display("FAIL selerr_pulse got=%h exp=%h", {sel_err, bus.out_valid, bus.out_data}, {1'b1, 1'b0, 16'hF000}); end
    SEL = 4'hF;
    @(negedge CLK);
    n_tests++;
    if (bus.in_ready !== 8'h00) begin n_fail++; $display("FAIL selidle_ready got=%h exp=%h", bus.in_ready, 8'h00); end
    tick();
    n_tests++;
    if ({sel_err, bus.out_valid, bus.out_data} !== {1'b0, 1'b0, 16'hF000}) begin
      n_fail++; $display("FAIL selidle_out got=%h exp=%h", {sel_err, bus.out_valid, bus.out_data}, {1'b0, 1'b0, 16'hF000}); end
    clear_in();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    SEL = 4'd4;
    bus.out_ready = 1'b0;
    drive(4, 16'hE001, 1'b0);
    tick();
    n_tests++;
    if ({bus.out_valid, bus.out_ch} !== {1'b1, 4'd4}) begin
      n_fail++; $display("FAIL rstmid_lock got=%h exp=%h", {bus.out_valid, bus.out_ch}, {1'b1, 4'd4}); end
    RST = 1'b1;
    drive(4, 16'hE002, 1'b0);
    @(negedge CLK);
    n_tests++;
    if (bus.in_ready !== 8'h00) begin n_fail++; $display("FAIL rstmid_ready got=%h exp=%h", bus.in_ready, 8'h00); end
    tick();
    RST = 1'b0;
    n_tests++;
    if ({bus.out_valid, bus.out_last, bus.out_ch, bus.out_data} !== {1'b0, 1'b0, 4'hF, 16'hF000}) begin
      n_fail++; $display("FAIL rstmid_out got=%h exp=%h", {bus.out_valid, bus.out_last, bus.out_ch, bus.out_data}, {1'b0, 1'b0, 4'hF, 16'hF000}); end
    SEL = 4'd6;
    bus.out_ready = 1'b1;
    drive(6, 16'hF106, 1'b1);
    @(negedge CLK);
    n_tests++;
    if (bus.in_ready !== 8'b0100_0000) begin n_fail++; $display("FAIL rstmid_newgrant got=%h exp=%h", bus.in_ready, 8'b0100_0000); end
    tick();
    n_tests++;
    if ({bus.out_valid, bus.out_ch, bus.out_data} !== {1'b1, 4'd6, 16'hF106}) begin
      n_fail++; $display("FAIL rstmid_newout got=%h exp=%h", {bus.out_valid, bus.out_ch, bus.out_data}, {1'b1, 4'd6, 16'hF106}); end
    clear_in();
  endtask

  // Reference model: who owns the output (a channel with an open packet, or
  // nobody), where the round-robin search starts, and the word being held.
  function automatic int pick(input logic mode, input int sel, input logic [NCH-1:0] v,
                              input int owner, input int ptr);
    if (owner >= 0) return owner;
    if (!mode) begin
      if (sel < NCH) begin
        if (v[sel]) return sel;
      end
      return -1;
    end
    for (int k = 0; k < NCH; k++)
      if (v[(ptr + k) % NCH]) return (ptr + k) % NCH;
    return -1;
  endfunction

  task automatic test_random();
    int owner = -1;
    int ptr = 0;
    logic m_ov = 1'b0;
    logic m_ol = 1'b0;
    logic m_err = 1'b0;
    logic [3:0] m_oc = 4'hF;
    logic [DATA_W-1:0] m_od = 16'hF000;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      int g;
      logic can;
      logic [NCH-1:0] exp_rdy;
      if ($urandom_range(0, 15) == 0) MODE = ~MODE;
      SEL = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, NCH - 1));
      for (int i = 0; i < NCH; i++) begin
        bus.in_data[i*DATA_W +: DATA_W] = 16'($urandom);
        bus.in_valid[i] = ($urandom_range(0, 9) < 7);
        bus.in_last[i]  = ($urandom_range(0, 2) == 0);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);

      g = pick(MODE, int'(SEL), bus.in_valid, owner, ptr);
      can = (g >= 0) && (!m_ov || bus.out_ready);
      exp_rdy = '0;
      if (can) exp_rdy[g] = 1'b1;
      @(negedge CLK);
      n_tests++;
      if (bus.in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_ready cyc%0d got=%h exp=%h", cyc, bus.in_ready, exp_rdy); end

      m_err = (owner < 0) && !MODE && (int'(SEL) >= NCH) && (SEL != 4'hF);
      if (can && bus.in_valid[g]) begin
        m_od = bus.in_data[g*DATA_W +: DATA_W];
        m_ol = bus.in_last[g];
        m_oc = 4'(g);
        m_ov = 1'b1;
        if (m_ol) begin
          owner = -1;
          ptr = (g + 1) % NCH;
        end else begin
          owner = g;
        end
      end else if (bus.out_ready) begin
        m_ov = 1'b0;
      end
      tick();
      n_tests++;
      if ({bus.out_valid, bus.out_last, bus.out_ch, bus.out_data} !== {m_ov, m_ol, m_oc, m_od}) begin
        n_fail++; $display("FAIL rand_out cyc%0d got=%h exp=%h", cyc, {bus.out_valid, bus.out_last, bus.out_ch, bus.out_data}, {m_ov, m_ol, m_oc, m_od}); end
      n_tests++;
      if (sel_err !== m_err) begin n_fail++; $display("FAIL rand_sel_err cyc%0d got=%b exp=%b", cyc, sel_err, m_err); end
    end
    clear_in();
  endtask

  initial begin
    RST = 1'b1;
    MODE = 1'b0;
    SEL = 4'hF;
    bus.out_ready = 1'b1;
    clear_in();
    test_reset();
    test_fixed_packet();
    test_lock_switch();
    test_rr_order();
    test_backpressure();
    test_sel_err();
    test_reset_mid_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
